// File: rtl/norm_unit.sv
// Multi-cycle CLZ / CLO / left-normalize unit with start/busy/done handshake.
// Define NRM_FAST_EN to skip four leading zeros per edge while the top nibble is clear.
module norm_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        NRM_Start,
   input  logic [31:0] NRM_DA,
   input  logic [1:0]  NRM_Func,
   output logic [31:0] NRM_DC,
   output logic [5:0]  NRM_Cnt,
   output logic        NRM_Busy,
   output logic        NRM_Done
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
   typedef enum logic [1:0] {F_NONE = 2'b00, F_CLZ = 2'b01, F_CLO = 2'b10, F_NORM = 2'b11} func_t;

   state_t      state_q;
   func_t       func_q;
   logic [31:0] scan_q, scan_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dc_q;
   logic [5:0]  cnt_out_q;
   logic        scan_end;

   assign scan_end = scan_q[31] || (cnt_q == 6'd32);

   // One scan step; only used while scan_end is low.
   always_comb begin
      // NOTE: defaults first so every path assigns both signals and no latch is inferred.
      scan_d = {scan_q[30:0], 1'b0};
      cnt_d  = cnt_q + 6'd1;
`ifdef NRM_FAST_EN
      if (scan_q[31:28] == 4'b0000 && cnt_q <= 6'd28) begin
         scan_d = {scan_q[27:0], 4'b0000};
         cnt_d  = cnt_q + 6'd4;
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         func_q    <= F_NONE;
         scan_q    <= '0;
         cnt_q     <= '0;
         dc_q      <= '0;
         cnt_out_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state_q)
            S_IDLE, S_DONE: begin
               if (NRM_Start) begin
                  func_q <= func_t'(NRM_Func);
                  scan_q <= (func_t'(NRM_Func) == F_CLO) ? ~NRM_DA : NRM_DA;
                  cnt_q  <= '0;
                  if (func_t'(NRM_Func) == F_NONE) begin
                     dc_q      <= '0;
                     cnt_out_q <= '0;
                     state_q   <= S_DONE;
                  end else begin
                     state_q <= S_SCAN;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SCAN: begin
               if (scan_end) begin
                  cnt_out_q <= cnt_q;
                  // For NORM the scan register already holds the operand shifted left by cnt.
                  dc_q      <= (func_q == F_NORM) ? scan_q : {26'b0, cnt_q};
                  state_q   <= S_DONE;
               end else begin
                  scan_q <= scan_d;
                  cnt_q  <= cnt_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign NRM_DC   = dc_q;
   assign NRM_Cnt  = cnt_out_q;
   assign NRM_Busy = (state_q == S_SCAN);
   assign NRM_Done = (state_q == S_DONE);

endmodule

// File: tb/tb_norm_unit.sv
// Randomized and directed bench for norm_unit against a leading-bit-count reference model.
module tb_norm_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        NRM_Start;
   logic [31:0] NRM_DA;
   logic [1:0]  NRM_Func;
   logic [31:0] NRM_DC;
   logic [5:0]  NRM_Cnt;
   logic        NRM_Busy;
   logic        NRM_Done;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int t_start = 0;

   norm_unit dut (
      .CLK       (CLK),
      .RST       (RST),
      .NRM_Start (NRM_Start),
      .NRM_DA    (NRM_DA),
      .NRM_Func  (NRM_Func),
      .NRM_DC    (NRM_DC),
      .NRM_Cnt   (NRM_Cnt),
      .NRM_Busy  (NRM_Busy),
      .NRM_Done  (NRM_Done)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int lead_zeros(input logic [31:0] v);
      int n = 0;
      while (n < 32 && v[31-n] == 1'b0) n++;
      return n;
   endfunction

   // Reference: result value, count, and cycles from Start sample to Done (inclusive).
   task automatic model(input logic [1:0] f, input logic [31:0] a,
                        output logic [31:0] dc, output int cnt, output int lat);
      case (f)
         2'b00: cnt = 0;
         2'b10: cnt = lead_zeros(~a);
         default: cnt = lead_zeros(a);
      endcase
      if (f == 2'b00)      dc = 32'd0;
      else if (f == 2'b11) dc = (cnt == 32) ? 32'd0 : (a << cnt);
      else                 dc = 32'(cnt);
`ifdef NRM_FAST_EN
      lat = (f == 2'b00) ? 1 : (cnt / 4) + (cnt % 4) + 2;
`else
      lat = (f == 2'b00) ? 1 : cnt + 2;
`endif
   endtask

   task automatic issue(input logic [1:0] f, input logic [31:0] a);
      @(negedge CLK);
      NRM_Start = 1'b1;
      NRM_DA    = a;
      NRM_Func  = f;
      @(posedge CLK);
      t_start = cyc + 1;
      #1;
      NRM_Start = 1'b0;
      NRM_DA    = $urandom;
      NRM_Func  = 2'($urandom);
      if (f == 2'b00) check("done after func00", 32'(NRM_Done), 32'd1);
      else            check("busy after start", 32'(NRM_Busy), 32'd1);
   endtask

   task automatic await_check(input string tag, input logic [1:0] f, input logic [31:0] a);
      logic [31:0] exp_dc;
      int          exp_cnt, exp_lat;
      model(f, a, exp_dc, exp_cnt, exp_lat);
      while (!NRM_Done && (cyc - t_start) < 40) begin
         @(posedge CLK);
         #1;
      end
      check({tag, " done seen"}, 32'(NRM_Done), 32'd1);
      check({tag, " dc"}, NRM_DC, exp_dc);
      check({tag, " cnt"}, 32'(NRM_Cnt), 32'(exp_cnt));
      check({tag, " latency"}, 32'(cyc - t_start + 1), 32'(exp_lat));
   endtask

   initial begin
      logic [1:0]  f;
      logic [31:0] a;
      int          seen;

      RST = 1'b1;
      NRM_Start = 1'b0;
      NRM_DA = '0;
      NRM_Func = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset dc", NRM_DC, 32'd0);
      check("reset cnt", 32'(NRM_Cnt), 32'd0);
      check("reset busy", 32'(NRM_Busy), 32'd0);
      check("reset done", 32'(NRM_Done), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      issue(2'b01, 32'h0001_0000);
      await_check("clz 0x10000", 2'b01, 32'h0001_0000);
      @(posedge CLK);
      #1;
      check("done one-cycle pulse", 32'(NRM_Done), 32'd0);

      issue(2'b10, 32'hFFFF_FFFF);
      await_check("clo all-ones", 2'b10, 32'hFFFF_FFFF);
      issue(2'b11, 32'h0000_0C00);
      await_check("norm 0xc00", 2'b11, 32'h0000_0C00);
      issue(2'b11, 32'h0000_0000);
      await_check("norm zero", 2'b11, 32'h0000_0000);
      issue(2'b00, 32'hDEAD_BEEF);
      await_check("func00", 2'b00, 32'hDEAD_BEEF);

      // Start while busy must not disturb the scan in progress.
      issue(2'b01, 32'h0000_4000);
      @(negedge CLK);
      NRM_Start = 1'b1;
      NRM_DA    = 32'hFFFF_FFFF;
      NRM_Func  = 2'b11;
      @(negedge CLK);
      NRM_Start = 1'b0;
      await_check("start ignored while busy", 2'b01, 32'h0000_4000);

      // Back-to-back: issue() starts inside the Done cycle and checks Busy next cycle.
      issue(2'b01, 32'h8000_0000);
      await_check("b2b first", 2'b01, 32'h8000_0000);
      issue(2'b10, 32'hF0F0_0000);
      await_check("b2b second", 2'b10, 32'hF0F0_0000);

      for (int i = 0; i < 60; i++) begin
         f = 2'($urandom);
         case ($urandom_range(0, 5))
            0:       a = 32'd0;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom >> $urandom_range(0, 31);
         endcase
         if (f == 2'b10) a = ~a;
         issue(f, a);
         await_check("random", f, a);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge CLK);
      end

      // Asynchronous reset in the middle of a long scan.
      issue(2'b01, 32'h0000_0001);
      repeat (4) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check("midscan reset dc", NRM_DC, 32'd0);
      check("midscan reset cnt", 32'(NRM_Cnt), 32'd0);
      check("midscan reset busy", 32'(NRM_Busy), 32'd0);
      check("midscan reset done", 32'(NRM_Done), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1;
         if (NRM_Done || NRM_Busy) seen = 1;
      end
      check("no activity after reset", 32'(seen), 32'd0);
      issue(2'b01, 32'h0000_0001);
      await_check("clz after reset", 2'b01, 32'h0000_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/norm_unit.md
# norm_unit

Multi-cycle count-leading-zeros/ones and left-normalize unit in the execute stage, beside the combinational shifter. It serves CLZ, CLO and the normalize step used by multi-cycle arithmetic. It accepts one operand per request, scans it from the MSB under a start/busy/done handshake, and returns either the leading-bit count or the left-justified operand.

## Interface
- Parameters: none; the datapath is fixed at 32 bits.
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-high
- NRM_Start  in  1  request strobe; sampled only while NRM_Busy=0
- NRM_DA  in  32  operand; sampled with NRM_Start
- NRM_Func  in  2  00 none (result 0), 01 CLZ, 10 CLO, 11 NORM; sampled with NRM_Start
- NRM_DC  out  32  result: count zero-extended (CLZ/CLO) or normalized value (NORM)
- NRM_Cnt  out  6  leading-bit count, 0..32
- NRM_Busy  out  1  high while scanning
- NRM_Done  out  1  one-cycle pulse; NRM_DC and NRM_Cnt are valid from this cycle

## Operation
- States:
  - IDLE, SCAN, DONE.
  - NRM_Busy = (state==SCAN).
  - NRM_Done = (state==DONE).
- IDLE or DONE with NRM_Start=1:
  - Latch func.
  - Scan register R = NRM_DA for CLZ/NORM, R = ~NRM_DA for CLO.
  - cnt=0.
  - Go to SCAN, except func=00, which goes straight to DONE with DC=0, Cnt=0.
- IDLE or DONE without Start: go to IDLE. Outputs hold their last result.
- SCAN each edge:
  - If R[31]=1 or cnt==32: load the outputs, then go to DONE.
  - Otherwise: R <= R<<1 (zero fill), cnt <= cnt+1.
- Output load:
  - NRM_Cnt = cnt.
  - CLZ/CLO: NRM_DC = {26'b0, cnt}.
  - NORM: NRM_DC = R, i.e. NRM_DA<<cnt.
- Zero operand (CLZ/NORM) or all-ones (CLO): cnt stops at 32. NORM result is 0.
- NRM_Start while Busy=1 is ignored. The operand and func of the scan in progress are never disturbed.
- Reset, at any time including mid-scan:
  - state=IDLE.
  - NRM_DC=0, NRM_Cnt=0, NRM_Busy=0, NRM_Done=0.
  - The scan in progress is abandoned with no Done pulse.

## Timing
- Start sampled at edge T; n = leading-bit count.
- Base latency:
  - Busy is high from T+1.
  - Done is high in the cycle after edge T+n+1, i.e. n+2 cycles after Start.
  - Worst case n=32: 34 cycles.
- func=00: Done in the cycle after edge T.
- Back-to-back: a Start presented during the Done cycle is accepted. The next scan begins with no idle gap.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- NRM_FAST_EN defined:
  - In SCAN, when R[31:28]==0 and cnt<=28, take R <= R<<4 and cnt <= cnt+4 in one edge.
  - Otherwise the single-bit step applies.
  - For n = 4q+r, latency is q+r+2 cycles. Zero operand: 10 cycles.
- NRM_FAST_EN undefined: single-bit step only.
- Results are identical in both builds; only latency differs.

## Test plan
- Reset mid-scan:
  - Stimulus: CLZ of 0x0000_0001, RST asserted at cycle 5.
  - Response: all outputs 0 immediately; no Done pulse; Busy=0; a following Start runs normally.
- CLZ of 0x0001_0000:
  - Response: Cnt=15, DC=0x0000_000F.
  - Done at 17 cycles (base build) or 8 cycles (FAST build).
- CLO of 0xFFFF_FFFF:
  - Response: Cnt=32, DC=0x0000_0020.
  - Done at 34 cycles (base) or 10 cycles (FAST).
- NORM of 0x0000_0C00:
  - Response: DC=0xC000_0000, Cnt=20.
- NORM of 0:
  - Response: DC=0, Cnt=32.
- Handshake and func=00:
  - Stimulus: Start pulsed while Busy with a different operand.
  - Response: ignored; the original result is returned.
  - Stimulus: func=00 with any operand.
  - Response: DC=0, Done in the cycle after Start.
  - Stimulus: a second Start presented in the Done cycle.
  - Response: accepted; Busy high on the next cycle.
